// File: rtl/simd_decode_unit_pkg.sv
// rtl/simd_decode_unit_pkg.sv - shared opcode, ALU and write-back constants plus control lookup
package simd_decode_unit_pkg;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 6'h01,
    OP_SUB   = 6'h02,
    OP_MUL   = 6'h03,
    OP_DIV   = 6'h04,
    OP_AND   = 6'h05,
    OP_ORR   = 6'h06,
    OP_LOAD  = 6'h10,
    OP_STORE = 6'h11,
    OP_CONST = 6'h12,
    OP_RET   = 6'h20
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_DIV  = 3'd4,
    ALU_AND  = 3'd5,
    ALU_ORR  = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    REG_WRITE_NONE = 2'd0,
    REG_WRITE_ALU  = 2'd1,
    REG_WRITE_LOAD = 2'd2,
    REG_WRITE_IMM  = 2'd3
  } reg_write_mux_e;

  typedef struct packed {
    alu_op_e        alu_op;
    reg_write_mux_e reg_write_mux;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           ret;
    logic           illegal;
  } ctrl_t;

  // Anything not in the table is flagged illegal with every side effect suppressed.
  function automatic ctrl_t lookup_ctrl(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LOAD: begin
        c.reg_write     = 1'b1;
        c.mem_read      = 1'b1;
        c.reg_write_mux = REG_WRITE_LOAD;
      end
      OP_STORE: c.mem_write = 1'b1;
      OP_ADD:   begin c.reg_write = 1'b1; c.alu_op = ALU_ADD; c.reg_write_mux = REG_WRITE_ALU; end
      OP_SUB:   begin c.reg_write = 1'b1; c.alu_op = ALU_SUB; c.reg_write_mux = REG_WRITE_ALU; end
      OP_MUL:   begin c.reg_write = 1'b1; c.alu_op = ALU_MUL; c.reg_write_mux = REG_WRITE_ALU; end
      OP_DIV:   begin c.reg_write = 1'b1; c.alu_op = ALU_DIV; c.reg_write_mux = REG_WRITE_ALU; end
      OP_AND:   begin c.reg_write = 1'b1; c.alu_op = ALU_AND; c.reg_write_mux = REG_WRITE_ALU; end
      OP_ORR:   begin c.reg_write = 1'b1; c.alu_op = ALU_ORR; c.reg_write_mux = REG_WRITE_ALU; end
      OP_CONST: begin c.reg_write = 1'b1; c.reg_write_mux = REG_WRITE_IMM; end
      OP_RET:   c.ret = 1'b1;
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/simd_decode_unit_decode_lut.sv
// rtl/simd_decode_unit_decode_lut.sv - combinational field extraction and control decode
module decode_lut
  import simd_decode_unit_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int REG_ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH        = 16,
  parameter int IMM_SIGNED        = 1
) (
  input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
  output logic [OPCODE_WIDTH-1:0]      o_op_code,
  output logic [REG_ADDR_WIDTH-1:0]    o_rd,
  output logic [REG_ADDR_WIDTH-1:0]    o_rm,
  output logic [REG_ADDR_WIDTH-1:0]    o_rn,
  output logic [DATA_WIDTH-1:0]        o_imm,
  output logic [2:0]                   o_alu_op,
  output logic [1:0]                   o_reg_write_mux,
  output logic                         o_reg_write,
  output logic                         o_mem_read,
  output logic                         o_mem_write,
  output logic                         o_ret,
  output logic                         o_illegal
);

  // The immediate spans everything below rd, so it overlaps the rm/rn slices.
  localparam int IMM_W = INSTRUCTION_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH;

  ctrl_t w_ctrl;

  assign o_op_code = i_instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign o_rd      = i_instruction[INSTRUCTION_WIDTH-OPCODE_WIDTH-1 -: REG_ADDR_WIDTH];
  assign o_rm      = i_instruction[INSTRUCTION_WIDTH-OPCODE_WIDTH-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign o_rn      = i_instruction[INSTRUCTION_WIDTH-OPCODE_WIDTH-2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];

  generate
    if (IMM_W >= DATA_WIDTH) begin : g_imm_trunc
      assign o_imm = i_instruction[DATA_WIDTH-1:0];
    end else if (IMM_SIGNED != 0) begin : g_imm_sext
      assign o_imm = {{(DATA_WIDTH-IMM_W){i_instruction[IMM_W-1]}}, i_instruction[IMM_W-1:0]};
    end else begin : g_imm_zext
      assign o_imm = {{(DATA_WIDTH-IMM_W){1'b0}}, i_instruction[IMM_W-1:0]};
    end
  endgenerate

  assign w_ctrl          = lookup_ctrl(OP_W'(o_op_code));
  assign o_alu_op        = w_ctrl.alu_op;
  assign o_reg_write_mux = w_ctrl.reg_write_mux;
  assign o_reg_write     = w_ctrl.reg_write;
  assign o_mem_read      = w_ctrl.mem_read;
  assign o_mem_write     = w_ctrl.mem_write;
  assign o_ret           = w_ctrl.ret;
  assign o_illegal       = w_ctrl.illegal;

endmodule

// File: rtl/simd_decode_unit.sv
// rtl/simd_decode_unit.sv - instruction decode with a 2-entry in-order output buffer
module simd_decode_unit
  import simd_decode_unit_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int REG_ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH        = 16,
  parameter int IMM_SIGNED        = 1,
  parameter int WARP_ID_WIDTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic [WARP_ID_WIDTH-1:0]     in_warp_id,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_WIDTH-1:0]      op_code,
  output logic [REG_ADDR_WIDTH-1:0]    rd,
  output logic [REG_ADDR_WIDTH-1:0]    rm,
  output logic [REG_ADDR_WIDTH-1:0]    rn,
  output logic [DATA_WIDTH-1:0]        imm,
  output logic [2:0]                   alu_op,
  output logic [1:0]                   reg_write_mux,
  output logic                         reg_write,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic                         ret,
  output logic                         illegal,
  output logic [WARP_ID_WIDTH-1:0]     out_warp_id
);

  localparam int BW = OPCODE_WIDTH + 3*REG_ADDR_WIDTH + DATA_WIDTH + 3 + 2 + 5 + WARP_ID_WIDTH;

  logic [OPCODE_WIDTH-1:0]   w_op_code;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [REG_ADDR_WIDTH-1:0] w_rm;
  logic [REG_ADDR_WIDTH-1:0] w_rn;
  logic [DATA_WIDTH-1:0]     w_imm;
  logic [2:0]                w_alu_op;
  logic [1:0]                w_reg_write_mux;
  logic                      w_reg_write;
  logic                      w_mem_read;
  logic                      w_mem_write;
  logic                      w_ret;
  logic                      w_illegal;
  logic [BW-1:0]             w_bundle;
  logic                      w_push;
  logic                      w_pop;

  logic [BW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  decode_lut #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .OPCODE_WIDTH      (OPCODE_WIDTH),
    .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH),
    .IMM_SIGNED        (IMM_SIGNED)
  ) u_decode_lut (
    .i_instruction   (instruction),
    .o_op_code       (w_op_code),
    .o_rd            (w_rd),
    .o_rm            (w_rm),
    .o_rn            (w_rn),
    .o_imm           (w_imm),
    .o_alu_op        (w_alu_op),
    .o_reg_write_mux (w_reg_write_mux),
    .o_reg_write     (w_reg_write),
    .o_mem_read      (w_mem_read),
    .o_mem_write     (w_mem_write),
    .o_ret           (w_ret),
    .o_illegal       (w_illegal)
  );

  assign w_bundle = {w_op_code, w_rd, w_rm, w_rn, w_imm, w_alu_op, w_reg_write_mux,
                     w_reg_write, w_mem_read, w_mem_write, w_ret, w_illegal, in_warp_id};

  // Handshake flags come only from the registered occupancy count.
  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign {op_code, rd, rm, rn, imm, alu_op, reg_write_mux,
          reg_write, mem_read, mem_write, ret, illegal, out_warp_id} = r_mem[r_rd_ptr];

  // Buffer state: reset clears storage so outputs read zero; flush only empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_bundle;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
